// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEFAULT_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WORD,
    ST_WRITE,
    ST_ERR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// MSB-first 8->32 shift register that collects one instruction word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  // word_next is the value the register takes on a shift, so the completed
  // word can be captured on the same edge that accepts its last byte.
  assign word_next = {word_q[23:0], byte_in};
  assign word_full = shift && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Shift register and byte counter; clear restarts word assembly.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: decodes a length-prefixed big-endian byte image into
// instruction-memory word writes while holding the core in reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_new;
  logic [IDX_W-1:0]   idx_q;
  logic               accept;
  logic               len_bad;
  logic               last_word;
  logic               asm_clear;
  logic               asm_shift;
  logic               word_full;
  logic [31:0]        asm_next;

  assign byte_ready = !rst && !load_start &&
                      (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_WORD});
  assign accept     = byte_valid && byte_ready;
  assign len_new    = {len_q[LEN_W-1:8], byte_in};
  assign len_bad    = (len_new == '0) || (32'(len_new) > DEPTH);
  assign last_word  = (32'(idx_q) + 32'd1) == 32'(len_q);
  assign asm_shift  = accept && (state_q == ST_WORD);
  assign asm_clear  = load_start || (state_q != ST_WORD);

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .byte_in   (byte_in),
    .word_next (asm_next),
    .word_full (word_full)
  );

  // Next-state decode; load_start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = ST_LEN_HI;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
        ST_LEN_LO: if (accept) state_d = len_bad ? ST_ERR : ST_WORD;
        ST_WORD:   if (word_full) state_d = ST_WRITE;
        ST_WRITE:  state_d = last_word ? ST_DONE : ST_WORD;
        ST_ERR:    state_d = ST_IDLE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State register, length/index bookkeeping and registered outputs.
  // The write strobe, address and data are loaded on the edge that accepts
  // the fourth byte so that they are valid throughout the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (load_start) begin
        cpu_hold <= 1'b1;
        err      <= 1'b0;
        idx_q    <= '0;
      end else begin
        case (state_q)
          ST_LEN_HI: if (accept) len_q[LEN_W-1:8] <= byte_in;
          ST_LEN_LO: if (accept) len_q[7:0] <= byte_in;
          ST_WORD: begin
            if (word_full) begin
              imem_we    <= 1'b1;
              imem_waddr <= BASE_ADDR + (32'(idx_q) << 2);
              imem_wdata <= asm_next;
            end
          end
          ST_WRITE: begin
            idx_q <= idx_q + IDX_W'(1);
            if (last_word) done <= 1'b1;
          end
          ST_ERR:  err      <= 1'b1;
          ST_DONE: cpu_hold <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that is the write-side counterpart of the core's instruction memory, which the core only ever reads by PC. It accepts a byte stream over a valid/ready handshake and decodes a length-prefixed, big-endian image into 32-bit words. Each word is written into instruction memory at consecutive byte addresses. While a load is in progress it holds the datapath in reset through `cpu_hold`.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory capacity in 32-bit words; maximum legal word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word; must be 4-byte aligned.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `rst`  in  1  synchronous active-high reset.
- `load_start`  in  1  one-cycle pulse; begins or restarts a load.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_waddr`  out  32  byte address of the word being written.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  drives the datapath `rst` (ORed with system reset) while a load is in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky image error flag.

## Operation
- Image format:
  - 2 bytes word count N, MSB first.
  - Then N words of 4 bytes each, MSB first: first byte → `wdata[31:24]`.
- FSM states: IDLE, LEN_HI, LEN_LO, WORD, WRITE, ERR, DONE.
- IDLE: `byte_ready`=0. `load_start` → LEN_HI, and in the same edge: `cpu_hold`←1, `err`←0, word index←0.
- LEN_HI / LEN_LO: `byte_ready`=1; each accepted byte loads count[15:8] / count[7:0].
- After LEN_LO:
  - If N==0 or N>DEPTH → ERR.
  - Otherwise → WORD with byte index 0.
- WORD: `byte_ready`=1. Each accepted byte shifts into the assembler. The 4th byte → WRITE.
- WRITE (exactly one cycle): `byte_ready`=0, `imem_we`=1.
  - `imem_waddr` = BASE_ADDR + 4·index; `imem_wdata` = assembled word.
  - Then index++; if index+1==N → DONE, else → WORD.
- DONE (one cycle): `done`=1, `cpu_hold` still 1. Next state IDLE with `cpu_hold`=0.
- ERR (one cycle): sets `err`=1 → IDLE. `cpu_hold` stays 1 until the next successful load completes.
- `load_start` in any non-IDLE state: restart at LEN_HI.
  - Word index and byte index cleared, `err` cleared.
  - Words already written stay in memory; no write occurs in the restart cycle.
- `byte_ready` is forced 0 in any cycle where `load_start`=1; a byte offered in that cycle is not consumed.
- A byte is transferred only on an edge where `byte_valid` && `byte_ready`. `byte_valid` low stalls indefinitely; there is no timeout.
- Word index width is clog2(DEPTH+1). Address arithmetic is 32-bit and wraps modulo 2^32; no bound check beyond N≤DEPTH.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_waddr`=BASE_ADDR, `imem_wdata`=0, `cpu_hold`=0, `done`=0, `err`=0, state IDLE.
- `rst` overrides everything including `load_start`. Reset mid-load: outputs return to reset values next edge, and `cpu_hold` drops.
- All outputs are registered except `byte_ready`, which is decoded from state and `load_start`.
- Latency:
  - 4th byte of a word accepted at edge t → `imem_we`=1 in cycle t+1 → `byte_ready`=1 again in cycle t+2.
  - Minimum 5 cycles per word.
  - Minimum load time: 2 + 5N cycles from the first length byte, plus 1 DONE cycle.
- `done` asserts in the cycle after the last WRITE cycle; `cpu_hold` deasserts one cycle after `done`.

## Structure
- Shared package `loader_pkg`: FSM state encoding, image length field width (16), bytes per word (4), default DEPTH.
- One sub-module, `word_assembler`:
  - 8→32 MSB-first shift register with a 2-bit byte counter and `clear` input.
  - Asserts `word_full` when the 4th byte is shifted in.
- The top module holds the FSM, length register, word index, address generation and output registers.

## Test plan
1. Reset: hold `rst` 3 cycles with `byte_valid`=1 → all outputs at reset values, no byte consumed.
2. Happy path: `load_start`, then bytes 00 02 | 20 08 00 05 | AC 09 00 04 with `byte_valid` always 1.
   - Writes (addr 0, 0x20080005) and (addr 4, 0xAC090004).
   - `done` pulse, then `cpu_hold` low; datapath fetches 0x20080005 at PC 0.
3. Back-pressure and gaps: same image with `byte_valid` toggling randomly → identical writes; exactly 2 `imem_we` pulses; `byte_ready` low in every WRITE cycle.
4. Length errors:
   - N=0 → `err`=1, `cpu_hold` stays 1, no writes.
   - With DEPTH=256, N=257 (01 01) → same response.
5. Restart: `load_start` after 1.5 words of an image with N=3, then a full N=1 image with word 0x12345678.
   - Write to addr 0 of 0x12345678; `err`=0; `done` once.
   - The byte offered in the `load_start` cycle is not consumed.
6. BASE_ADDR=32'h100, N=1 → `imem_waddr`=0x100; reset asserted during WORD → `cpu_hold`=0 next edge, no further writes.
